// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg
//   Shared types for the combination-lock controller: FSM state encoding,
//   the registered output bundle, and the per-state output decode.
//   No ports. Imported by combo_lock_ctrl.
package combo_lock_pkg;

  typedef enum logic [3:0] {
    ST_LOCKED   = 4'd0,
    ST_START    = 4'd1,
    ST_ENTRY    = 4'd2,
    ST_OPENING  = 4'd3,
    ST_UNLOCKED = 4'd4,
    ST_PROG     = 4'd5,
    ST_RELOCK   = 4'd6,
    ST_FAIL     = 4'd7,
    ST_LOCKOUT  = 4'd8
  } state_e;

  typedef struct packed {
    logic count_en;
    logic clr_count;
    logic actuate_lock;
    logic open_cls;
    logic blank;
    logic safe_open;
    logic lockout;
  } outs_t;

  //                                   cnt  clr  act  ocl  blk  safe lko
  localparam outs_t OUTS_LOCKED   = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t OUTS_DIAL     = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t OUTS_OPENING  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0};
  localparam outs_t OUTS_UNLOCKED = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam outs_t OUTS_PROG     = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam outs_t OUTS_RELOCK   = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t OUTS_FAIL     = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t OUTS_LOCKOUT  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};

  function automatic outs_t decode_outs(input state_e st);
    outs_t o;
    case (st)
      ST_LOCKED:   o = OUTS_LOCKED;
      ST_START:    o = OUTS_DIAL;
      ST_ENTRY:    o = OUTS_DIAL;
      ST_OPENING:  o = OUTS_OPENING;
      ST_UNLOCKED: o = OUTS_UNLOCKED;
      ST_PROG:     o = OUTS_PROG;
      ST_RELOCK:   o = OUTS_RELOCK;
      ST_FAIL:     o = OUTS_FAIL;
      ST_LOCKOUT:  o = OUTS_LOCKOUT;
      default:     o = OUTS_LOCKED;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/combo_code_reg.sv
// combo_code_reg
//   Stores the N_DIGITS x DIGIT_W combination plus a shadow copy used while
//   reprogramming. Digits are written into the shadow one at a time; commit
//   copies the whole shadow (including a digit written in the same cycle)
//   into the live code so a partial program never becomes visible.
// Ports
//   clk_i      clock
//   rst_ni     async active-low reset, loads DEFAULT_CODE into code and shadow
//   wr_en_i    write wr_data_i into shadow digit wr_idx_i
//   wr_idx_i   shadow digit index
//   wr_data_i  digit value
//   commit_i   copy shadow (with this cycle's write) into live code
//   rd_idx_i   live code digit index
//   rd_data_o  live code digit value
module combo_code_reg #(
  parameter int N_DIGITS = 3,
  parameter int DIGIT_W  = 6,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = {6'd30, 6'd20, 6'd10}
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [$clog2(N_DIGITS)-1:0] wr_idx_i,
  input  logic [DIGIT_W-1:0]          wr_data_i,
  input  logic                        commit_i,
  input  logic [$clog2(N_DIGITS)-1:0] rd_idx_i,
  output logic [DIGIT_W-1:0]          rd_data_o
);

  logic [N_DIGITS-1:0][DIGIT_W-1:0] code_q;
  logic [N_DIGITS-1:0][DIGIT_W-1:0] shadow_q;
  logic [N_DIGITS-1:0][DIGIT_W-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i) shadow_d[wr_idx_i] = wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q   <= DEFAULT_CODE;
      shadow_q <= DEFAULT_CODE;
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) code_q <= shadow_d;
    end
  end

  assign rd_data_o = code_q[rd_idx_i];

endmodule

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl
//   Master controller for the dial-combination safe. Tracks digit entry
//   from the dial counter, compares against the stored code, drives the bolt
//   actuator, allows reprogramming while open, and enforces a timed lockout
//   after MAX_FAILS consecutive failed attempts.
// Ports
//   clk, rst                 clock / async active-low reset
//   cnten, up, dirch         dial counter status; dirch confirms a digit
//   dial_val                 current dial value
//   open, lock, prog         request pulses; doorCls = door closed sensor
//   countEn, clrCount        dial counter control
//   actuateLock, openCls     bolt drive, openCls=1 retracts
//   sel, blank               display digit select / blank
//   safeOpen, lockout        status
//   fail_cnt                 consecutive failed attempts
//
// state     | meaning
// ----------+-------------------------------------------------------------
// LOCKED    | closed, waiting for open request
// START     | waiting for dial to stop in the down direction
// ENTRY     | collecting digits, idx = digit being entered
// OPENING   | one-cycle bolt retract
// UNLOCKED  | safe open
// PROG      | writing new code into shadow, idx = digit being written
// RELOCK    | one-cycle bolt extend
// FAIL      | one-cycle failed-attempt bookkeeping
// LOCKOUT   | timed lockout, all requests ignored
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int N_DIGITS    = 3,
  parameter int DIGIT_W     = 6,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = {6'd30, 6'd20, 6'd10}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cnten,
  input  logic                           up,
  input  logic                           dirch,
  input  logic [DIGIT_W-1:0]             dial_val,
  input  logic                           open,
  input  logic                           lock,
  input  logic                           doorCls,
  input  logic                           prog,
  output logic                           countEn,
  output logic                           clrCount,
  output logic                           actuateLock,
  output logic                           openCls,
  output logic [$clog2(N_DIGITS)-1:0]    sel,
  output logic                           blank,
  output logic                           safeOpen,
  output logic                           lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_W = $clog2(LOCKOUT_CYC + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LOCKOUT_CYC - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               bad_q;
  logic [FC_W-1:0]    fail_cnt_q;
  logic [FC_W-1:0]    fail_cnt_d;
  logic [TMR_W-1:0]   timer_q;
  outs_t              outs_q;
  logic [IDX_W-1:0]   sel_q;

  logic [DIGIT_W-1:0] code_digit;
  logic               digit_match;
  logic               relock_req;
  logic               code_wr;
  logic               code_commit;

  assign relock_req  = lock && doorCls;
  assign digit_match = (code_digit == dial_val);
  // A relock request in PROG aborts, so it must also suppress the write.
  assign code_wr     = (state_q == ST_PROG) && dirch && !relock_req;
  assign code_commit = code_wr && (idx_q == IDX_LAST);
  assign fail_cnt_d  = (fail_cnt_q == FC_MAX) ? FC_MAX : fail_cnt_q + 1'b1;

  combo_code_reg #(
    .N_DIGITS     (N_DIGITS),
    .DIGIT_W      (DIGIT_W),
    .DEFAULT_CODE (DEFAULT_CODE)
  ) u_code (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (code_wr),
    .wr_idx_i  (idx_q),
    .wr_data_i (dial_val),
    .commit_i  (code_commit),
    .rd_idx_i  (idx_q),
    .rd_data_o (code_digit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOCKED;
      idx_q      <= '0;
      bad_q      <= 1'b0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      outs_q     <= OUTS_LOCKED;
      sel_q      <= '0;
    end else begin
      // Outputs follow the state one cycle behind its entry.
      outs_q <= decode_outs(state_q);
      sel_q  <= (state_q == ST_START || state_q == ST_ENTRY || state_q == ST_PROG)
                ? idx_q : '0;

      case (state_q)
        ST_LOCKED: begin
          if (open) begin
            state_q <= ST_START;
            idx_q   <= '0;
            bad_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (!cnten && !up) state_q <= ST_ENTRY;
        end
        ST_ENTRY: begin
          if (idx_q != IDX_LAST) begin
            if (dirch) begin
              bad_q <= bad_q | ~digit_match;
              idx_q <= idx_q + 1'b1;
            end
          end else if (open) begin
            state_q <= (!bad_q && digit_match) ? ST_OPENING : ST_FAIL;
          end else if (dirch && !digit_match) begin
            // An early mismatch on the last digit fails immediately;
            // a matching dirch just waits for open.
            state_q <= ST_FAIL;
          end
        end
        ST_OPENING: begin
          fail_cnt_q <= '0;
          state_q    <= ST_UNLOCKED;
        end
        ST_UNLOCKED: begin
          if (relock_req) begin
            state_q <= ST_RELOCK;
          end else if (prog) begin
            state_q <= ST_PROG;
            idx_q   <= '0;
          end
        end
        ST_PROG: begin
          if (relock_req) begin
            state_q <= ST_RELOCK;
          end else if (dirch) begin
            if (idx_q == IDX_LAST) begin
              state_q <= ST_UNLOCKED;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_RELOCK: begin
          state_q <= ST_LOCKED;
        end
        ST_FAIL: begin
          fail_cnt_q <= fail_cnt_d;
          if (fail_cnt_d == FC_MAX) begin
            state_q <= ST_LOCKOUT;
            timer_q <= TMR_INIT;
          end else begin
            state_q <= ST_LOCKED;
          end
        end
        ST_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q    <= ST_LOCKED;
            fail_cnt_q <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= ST_LOCKED;
      endcase
    end
  end

  assign countEn     = outs_q.count_en;
  assign clrCount    = outs_q.clr_count;
  assign actuateLock = outs_q.actuate_lock;
  assign openCls     = outs_q.open_cls;
  assign blank       = outs_q.blank;
  assign safeOpen    = outs_q.safe_open;
  assign lockout     = outs_q.lockout;
  assign sel         = sel_q;
  assign fail_cnt    = fail_cnt_q;

endmodule
